// File: rtl/store_check_pkg.sv
// store_check_pkg: FSM encoding and default knobs shared by the
// store_checker bus monitor and its expected-store table.
package store_check_pkg;

  typedef logic [2:0] state_t;

  localparam state_t S_IDLE = 3'd0;
  localparam state_t S_RUN  = 3'd1;
  localparam state_t S_PASS = 3'd2;
  localparam state_t S_FAIL = 3'd3;
  localparam state_t S_TOUT = 3'd4;

  localparam int DEF_IGN_ADDR = 80;
  localparam int DEF_TIMEOUT  = 1000;

endpackage

// File: rtl/store_check_table.sv
// store_check_table: NUM_EXP x (addr,data) expected-store regfile,
// one synchronous write port, asynchronous read at the compare index.
module store_check_table #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int NUM_EXP = 4,
  parameter int IW      = 2
) (
  input  logic          clk,
  input  logic          we,
  input  logic [IW-1:0] widx,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [IW-1:0] ridx,
  output logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [AW-1:0] addr_q [NUM_EXP];
  logic [DW-1:0] data_q [NUM_EXP];

  // Contents survive reset so a table loaded once can be re-run.
  always_ff @(posedge clk) begin
    if (we) begin
      addr_q[widx] <= waddr;
      data_q[widx] <= wdata;
    end
  end

  always_comb begin
    raddr = '0;
    rdata = '0;
    if (int'(ridx) < NUM_EXP) begin
      raddr = addr_q[ridx];
      rdata = data_q[ridx];
    end
  end

endmodule

// File: rtl/store_checker.sv
// store_checker: in-order check of memwrite stores against a table.
// Optional STORE_CHECK_CAPTURE_EN latches the first offending store.
module store_checker
  import store_check_pkg::*;
#(
  parameter int            AW       = 32,
  parameter int            DW       = 32,
  parameter int            NUM_EXP  = 4,
  parameter int            IW       = 2,
  parameter logic [AW-1:0] IGN_ADDR = AW'(DEF_IGN_ADDR),
  parameter int            TIMEOUT  = DEF_TIMEOUT,
  parameter int            CW       = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          memwrite,
  input  logic [AW-1:0] dataadr,
  input  logic [DW-1:0] writedata,
  input  logic          exp_we,
  input  logic [IW-1:0] exp_idx,
  input  logic [AW-1:0] exp_addr,
  input  logic [DW-1:0] exp_data,
  output logic          done,
  output logic          pass,
  output logic          fail,
  output logic          timeout,
  output logic [CW-1:0] match_cnt,
  output logic [CW-1:0] cycle_cnt,
  output logic [AW-1:0] bad_addr,
  output logic [DW-1:0] bad_data
);

  state_t state, state_n;

  logic [IW-1:0] idx;
  logic [AW-1:0] tbl_addr;
  logic [DW-1:0] tbl_data;

  logic run, arm, tbl_we, at_limit;
  logic hit, fin, bad, expire;

  assign run      = state == S_RUN;
  assign arm      = start && !run;
  assign tbl_we   = exp_we && !run && (int'(exp_idx) < NUM_EXP);
  assign at_limit = cycle_cnt == CW'(TIMEOUT - 1);

  store_check_table #(
    .AW      (AW),
    .DW      (DW),
    .NUM_EXP (NUM_EXP),
    .IW      (IW)
  ) u_tbl (
    .clk   (clk),
    .we    (tbl_we),
    .widx  (exp_idx),
    .waddr (exp_addr),
    .wdata (exp_data),
    .ridx  (idx),
    .raddr (tbl_addr),
    .rdata (tbl_data)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= S_IDLE;
      pass    <= 1'b0;
      fail    <= 1'b0;
      timeout <= 1'b0;
    end else begin
      state   <= state_n;
      pass    <= state_n == S_PASS;
      fail    <= state_n == S_FAIL;
      timeout <= state_n == S_TOUT;
    end
  end

  // Events are made exclusive: a completing store beats the timeout.
  always_comb begin
    hit     = 1'b0;
    fin     = 1'b0;
    bad     = 1'b0;
    expire  = 1'b0;
    state_n = state;
    if (run && memwrite) begin
      if (dataadr == tbl_addr && writedata == tbl_data) begin
        hit = 1'b1;
        fin = idx == IW'(NUM_EXP - 1);
      end else if (dataadr != IGN_ADDR) begin
        bad = 1'b1;
      end
    end
    expire = run && at_limit && !fin && !bad;
    unique case (1'b1)
      arm:     state_n = S_RUN;
      fin:     state_n = S_PASS;
      bad:     state_n = S_FAIL;
      expire:  state_n = S_TOUT;
      default: state_n = state;
    endcase
  end

  always_comb begin
    done = pass | fail | timeout;
  end

  // The timing-out edge does not count, so cycle_cnt stops at TIMEOUT-1.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idx       <= '0;
      match_cnt <= '0;
      cycle_cnt <= '0;
    end else if (arm) begin
      idx       <= '0;
      match_cnt <= '0;
      cycle_cnt <= '0;
    end else if (run) begin
      if (!expire && cycle_cnt != '1)
        cycle_cnt <= cycle_cnt + 1'b1;
      if (hit) begin
        idx       <= idx + 1'b1;
        match_cnt <= match_cnt + 1'b1;
      end
    end
  end

`ifdef STORE_CHECK_CAPTURE_EN
  logic [AW-1:0] cap_addr;
  logic [DW-1:0] cap_data;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cap_addr <= '0;
      cap_data <= '0;
    end else if (arm) begin
      cap_addr <= '0;
      cap_data <= '0;
    end else if (bad) begin
      cap_addr <= dataadr;
      cap_data <= writedata;
    end
  end

  assign bad_addr = cap_addr;
  assign bad_data = cap_data;
`else
  assign bad_addr = '0;
  assign bad_data = '0;
`endif

endmodule

// File: tb/tb_store_checker.sv
// tb_store_checker: vector table + scoreboard for a 4-entry checker,
// plus directed sequences on a 1-entry checker and timeout corners.
module tb_store_checker;

  logic        clk;
  logic        reset;
  logic        start4, start1;
  logic        memwrite;
  logic [31:0] dataadr, writedata;
  logic        exp_we4, exp_we1;
  logic [1:0]  exp_idx4;
  logic [0:0]  exp_idx1;
  logic [31:0] exp_addr, exp_data;

  logic        done4, pass4, fail4, tout4;
  logic [15:0] mc4, cc4;
  logic [31:0] ba4, bd4;
  logic        done1, pass1, fail1, tout1;
  logic [15:0] mc1, cc1;
  logic [31:0] ba1, bd1;

  int checks = 0;
  int failures = 0;

  store_checker #(.NUM_EXP(4), .IW(2), .TIMEOUT(20)) dut4 (
    .clk(clk), .reset(reset), .start(start4),
    .memwrite(memwrite), .dataadr(dataadr), .writedata(writedata),
    .exp_we(exp_we4), .exp_idx(exp_idx4),
    .exp_addr(exp_addr), .exp_data(exp_data),
    .done(done4), .pass(pass4), .fail(fail4), .timeout(tout4),
    .match_cnt(mc4), .cycle_cnt(cc4),
    .bad_addr(ba4), .bad_data(bd4)
  );

  store_checker #(.NUM_EXP(1), .IW(1), .TIMEOUT(20)) dut1 (
    .clk(clk), .reset(reset), .start(start1),
    .memwrite(memwrite), .dataadr(dataadr), .writedata(writedata),
    .exp_we(exp_we1), .exp_idx(exp_idx1),
    .exp_addr(exp_addr), .exp_data(exp_data),
    .done(done1), .pass(pass1), .fail(fail1), .timeout(tout1),
    .match_cnt(mc1), .cycle_cnt(cc1),
    .bad_addr(ba1), .bad_data(bd1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        st;
    logic        mw;
    logic [31:0] a;
    logic [31:0] d;
    int          mc;
    int          cc;
    logic        p;
    logic        f;
  } vec_t;

  typedef struct {
    int   id;
    int   mc;
    int   cc;
    logic p;
    logic f;
  } exp_t;

  vec_t vt[14];
  exp_t sb[$];

  function automatic vec_t mk(input logic st, mw, input int a, d,
                              input int mc, cc, input logic p, f);
    vec_t v;
    v.st = st; v.mw = mw; v.a = 32'(a); v.d = 32'(d);
    v.mc = mc; v.cc = cc; v.p = p; v.f = f;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk4(input string t, input int mc, cc,
                      input logic p, f, to);
    chk({t, ".mc"}, 64'(mc4), 64'(mc));
    chk({t, ".cc"}, 64'(cc4), 64'(cc));
    chk({t, ".pass"}, 64'(pass4), 64'(p));
    chk({t, ".fail"}, 64'(fail4), 64'(f));
    chk({t, ".tout"}, 64'(tout4), 64'(to));
    chk({t, ".done"}, 64'(done4), 64'(p | f | to));
  endtask

  task automatic wr4(input int i, input int a, d);
    exp_we4 = 1'b1; exp_idx4 = 2'(i);
    exp_addr = 32'(a); exp_data = 32'(d);
    cyc();
    exp_we4 = 1'b0;
  endtask

  task automatic st(input int a, d);
    memwrite = 1'b1; dataadr = 32'(a); writedata = 32'(d);
    cyc();
    memwrite = 1'b0;
  endtask

  task automatic go4();
    start4 = 1'b1;
    cyc();
    start4 = 1'b0;
  endtask

  task automatic go1();
    start1 = 1'b1;
    cyc();
    start1 = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cyc();
  endtask

  initial begin
    exp_t e;
    reset = 1'b0; start4 = 1'b0; start1 = 1'b0;
    memwrite = 1'b0; dataadr = '0; writedata = '0;
    exp_we4 = 1'b0; exp_we1 = 1'b0; exp_idx4 = '0; exp_idx1 = '0;
    exp_addr = '0; exp_data = '0;
    idle(2);
    chk4("rst", 0, 0, 0, 0, 0);
    chk("rst.bad_addr", 64'(ba4), 0);
    chk("rst.done1", 64'(done1), 0);
    reset = 1'b1;
    cyc();

    // T1: single-entry table, ignored store at 80 then the match
    exp_we1 = 1'b1; exp_idx1 = 1'b0; exp_addr = 84; exp_data = 7;
    cyc();
    exp_we1 = 1'b0;
    go1();
    st(80, 5);
    chk("t1.ign.pass", 64'(pass1), 0);
    chk("t1.ign.mc", 64'(mc1), 0);
    chk("t1.ign.fail", 64'(fail1), 0);
    st(84, 7);
    chk("t1.pass", 64'(pass1), 1);
    chk("t1.done", 64'(done1), 1);
    chk("t1.mc", 64'(mc1), 1);
    chk("t1.fail", 64'(fail1), 0);
    chk("t1.cc", 64'(cc1), 2);
    st(3, 3);
    chk("t1.sticky.pass", 64'(pass1), 1);
    chk("t1.sticky.fail", 64'(fail1), 0);
    chk("t1.frozen.cc", 64'(cc1), 2);

    // T2: table write during RUN is dropped; wrong data fails
    go1();
    chk("t2.arm.pass", 64'(pass1), 0);
    chk("t2.arm.cc", 64'(cc1), 0);
    exp_we1 = 1'b1; exp_idx1 = 1'b0; exp_addr = 84; exp_data = 6;
    cyc();
    exp_we1 = 1'b0;
    st(84, 6);
    chk("t2.fail", 64'(fail1), 1);
    chk("t2.pass", 64'(pass1), 0);
    chk("t2.mc", 64'(mc1), 0);
`ifdef STORE_CHECK_CAPTURE_EN
    chk("t2.bad_addr", 64'(ba1), 84);
    chk("t2.bad_data", 64'(bd1), 6);
`else
    chk("t2.bad_addr", 64'(ba1), 0);
    chk("t2.bad_data", 64'(bd1), 0);
`endif
    st(84, 7);
    chk("t2.sticky.fail", 64'(fail1), 1);
    chk("t2.sticky.pass", 64'(pass1), 0);

    // T3: four-entry table through the vector scoreboard
    wr4(0, 0, 1);
    wr4(1, 4, 2);
    wr4(2, 8, 3);
    wr4(3, 84, 7);
    vt[0]  = mk(1, 0, 0, 0, 0, 0, 0, 0);
    vt[1]  = mk(0, 1, 0, 1, 1, 1, 0, 0);
    vt[2]  = mk(0, 1, 80, 99, 1, 2, 0, 0);
    vt[3]  = mk(0, 0, 4, 2, 1, 3, 0, 0);
    vt[4]  = mk(0, 1, 4, 2, 2, 4, 0, 0);
    vt[5]  = mk(0, 1, 80, 0, 2, 5, 0, 0);
    vt[6]  = mk(0, 1, 8, 3, 3, 6, 0, 0);
    vt[7]  = mk(0, 1, 80, 5, 3, 7, 0, 0);
    vt[8]  = mk(0, 1, 84, 7, 4, 8, 1, 0);
    vt[9]  = mk(0, 1, 1, 1, 4, 8, 1, 0);
    vt[10] = mk(1, 1, 0, 1, 0, 0, 0, 0);
    vt[11] = mk(0, 1, 0, 1, 1, 1, 0, 0);
    vt[12] = mk(0, 1, 5, 2, 1, 2, 0, 1);
    vt[13] = mk(0, 0, 0, 0, 1, 2, 0, 1);
    for (int i = 0; i < 14; i++) begin
      start4 = vt[i].st;
      memwrite = vt[i].mw;
      dataadr = vt[i].a;
      writedata = vt[i].d;
      sb.push_back('{i, vt[i].mc, vt[i].cc, vt[i].p, vt[i].f});
      cyc();
      start4 = 1'b0;
      memwrite = 1'b0;
      e = sb.pop_front();
      chk4($sformatf("v%0d", e.id), e.mc, e.cc, e.p, e.f, 1'b0);
    end

    // T4: timeout, then final match and mismatch on the last cycle
    go4();
    idle(19);
    chk4("t4.pre", 0, 19, 0, 0, 0);
    cyc();
    chk4("t4.tout", 0, 19, 0, 0, 1);
    cyc();
    chk4("t4.held", 0, 19, 0, 0, 1);
    go4();
    chk4("t4b.arm", 0, 0, 0, 0, 0);
    st(0, 1);
    st(4, 2);
    st(8, 3);
    idle(16);
    chk4("t4b.pre", 3, 19, 0, 0, 0);
    st(84, 7);
    chk("t4b.pass", 64'(pass4), 1);
    chk("t4b.tout", 64'(tout4), 0);
    chk("t4b.mc", 64'(mc4), 4);
    go4();
    idle(19);
    st(7, 7);
    chk("t4c.fail", 64'(fail4), 1);
    chk("t4c.tout", 64'(tout4), 0);

    // T5: asynchronous reset in the middle of a run
    go4();
    st(0, 1);
    st(4, 2);
    chk("t5.mc", 64'(mc4), 2);
    #2 reset = 1'b0;
    #1;
    chk4("t5.rst", 0, 0, 0, 0, 0);
    chk("t5.rst.done1", 64'(done1), 0);
    #1 reset = 1'b1;
    cyc();
    go4();
    st(0, 1);
    st(4, 2);
    st(8, 3);
    st(84, 7);
    chk4("t5.pass", 4, 4, 1, 0, 0);

    // T6: fail, reload entry 0, re-arm; start inside RUN is ignored
    go4();
    st(9, 9);
    chk("t6.fail", 64'(fail4), 1);
`ifdef STORE_CHECK_CAPTURE_EN
    chk("t6.bad_addr", 64'(ba4), 9);
`else
    chk("t6.bad_addr", 64'(ba4), 0);
`endif
    wr4(0, 12, 5);
    go4();
    chk4("t6.arm", 0, 0, 0, 0, 0);
    chk("t6.arm.bad_addr", 64'(ba4), 0);
    st(12, 5);
    st(4, 2);
    go4();
    chk4("t6.restart", 2, 3, 0, 0, 0);
    st(8, 3);
    st(84, 7);
    chk4("t6.pass", 4, 5, 1, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
